// File: rtl/memc_deskew.sv
// -----------------------------------------------------------------------------
// memc_deskew
//
// Realigns the skewed rows leaving a systolic array. On the input side, lane i
// of a row arrives i cycles after lane 0. On the output side, all DIM lanes of
// that row are presented together on Cout in a single cycle, and out_valid is
// raised for that cycle.
//
// Lane i goes through DIM-1-i pipeline registers and then through the shared
// output register. Its total latency is therefore DIM-i cycles. A row whose
// in_valid cycle is t appears on Cout at cycle t+DIM. The pipeline has no stall
// path: every delay line shifts on every clock.
//
// Ports
//    clk        : sole clock; all state changes on the rising edge
//    rst        : synchronous active-high reset
//    in_valid   : lane 0 of Cin carries element 0 of a new row this cycle
//    Cin        : skewed row data, DIM lanes of BITS_C bits each
//    out_valid  : Cout holds a complete, realigned row this cycle
//    Cout       : realigned row (registered, holds between valid rows)
//    row_idx    : position within the matrix of the row currently on Cout
//    last_row   : out_valid for the final row (row_idx == NUM_ROWS-1)
// -----------------------------------------------------------------------------
module memc_deskew #(
   parameter int BITS_C   = 24,
   parameter int DIM      = 8,
   parameter int NUM_ROWS = 8,
   localparam int RIW     = ($clog2(NUM_ROWS) > 1) ? $clog2(NUM_ROWS) : 1
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               in_valid,
   input  logic signed [DIM-1:0][BITS_C-1:0]  Cin,
   output logic                               out_valid,
   output logic signed [DIM-1:0][BITS_C-1:0]  Cout,
   output logic        [RIW-1:0]              row_idx,
   output logic                               last_row
);

   localparam logic [RIW-1:0] LAST_IDX = RIW'(NUM_ROWS - 1);

   // Lane values that belong to a single source row. They become mutually
   // aligned one cycle before that row is due on Cout.
   logic [DIM-1:0][BITS_C-1:0] aligned;

   // -------------------------------------------------------------------------
   // Per-lane delay lines. Lane DIM-1 is the last lane to arrive, so it needs
   // no delay register and feeds the output register directly.
   // -------------------------------------------------------------------------
   for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
      if (gi == DIM - 1) begin : g_direct
         assign aligned[gi] = Cin[gi];
      end else begin : g_dly
         localparam int DEPTH = DIM - 1 - gi;

         logic [BITS_C-1:0] dly_q [DEPTH];
         logic [BITS_C-1:0] dly_d [DEPTH];

         // Next state of the lane shift register: Cin enters at stage 0.
         always_comb begin
            dly_d[0] = Cin[gi];
            for (int k = 1; k < DEPTH; k++) begin
               dly_d[k] = dly_q[k-1];
            end
         end

         // Lane shift register; unconditional shift, cleared by reset.
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < DEPTH; k++) begin
                  dly_q[k] <= {BITS_C{1'b0}};
               end
            end else begin
               for (int k = 0; k < DEPTH; k++) begin
                  dly_q[k] <= dly_d[k];
               end
            end
         end

         assign aligned[gi] = dly_q[DEPTH-1];
      end
   end

   // -------------------------------------------------------------------------
   // Valid tracking. Bit k is set when an in_valid pulse occurred k+1 cycles
   // ago. The top bit is out_valid. The bit below it tells us that the output
   // register must capture the aligned lanes on this edge.
   // -------------------------------------------------------------------------
   logic [DIM-1:0] vld_q;
   logic [DIM-1:0] vld_d;
   logic           load_row;

   // Next state of the valid shift register.
   always_comb begin
      vld_d = {vld_q[DIM-2:0], in_valid};
   end

   // Valid shift register. On reset, every row in flight is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q <= {DIM{1'b0}};
      end else begin
         vld_q <= vld_d;
      end
   end

   assign load_row = vld_q[DIM-2];

   // -------------------------------------------------------------------------
   // Output register. It only loads when a row is completing, so Cout keeps
   // the last row it presented during idle cycles.
   // -------------------------------------------------------------------------
   logic [DIM-1:0][BITS_C-1:0] cout_q;
   logic [DIM-1:0][BITS_C-1:0] cout_d;

   // Next state of the output register: capture or hold.
   always_comb begin
      if (load_row) begin
         cout_d = aligned;
      end else begin
         cout_d = cout_q;
      end
   end

   // Output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cout_q <= {(DIM*BITS_C){1'b0}};
      end else begin
         cout_q <= cout_d;
      end
   end

   // -------------------------------------------------------------------------
   // Row index within the matrix. It advances in the cycle after each
   // presented row and wraps at the end of the matrix.
   // -------------------------------------------------------------------------
   logic [RIW-1:0] row_idx_q;
   logic [RIW-1:0] row_idx_d;

   // Next row index.
   always_comb begin
      if (vld_q[DIM-1]) begin
         if (row_idx_q == LAST_IDX) begin
            row_idx_d = {RIW{1'b0}};
         end else begin
            row_idx_d = row_idx_q + RIW'(1'b1);
         end
      end else begin
         row_idx_d = row_idx_q;
      end
   end

   // Row index register.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_idx_q <= {RIW{1'b0}};
      end else begin
         row_idx_q <= row_idx_d;
      end
   end

   // Output drive. last_row is decoded combinationally from registered state.
   always_comb begin
      out_valid = vld_q[DIM-1];
      Cout      = cout_q;
      row_idx   = row_idx_q;
      if (vld_q[DIM-1] && (row_idx_q == LAST_IDX)) begin
         last_row = 1'b1;
      end else begin
         last_row = 1'b0;
      end
   end

endmodule

// File: tb/tb_memc_deskew.sv
// -----------------------------------------------------------------------------
// Testbench for memc_deskew.
//
// Each cycle's inputs are stored in history arrays. The reference model reads
// those arrays to work out what the DUT should output:
//    out_valid(c) : in_valid was set at cycle c-DIM and no reset was sampled
//                   in cycles c-DIM .. c-1
//    Cout(c)      : lane i = Cin[i] recorded at cycle c-DIM+i when valid;
//                   zero after a reset; otherwise the previous value
//    row_idx(c)   : number of valid rows since the last reset, mod NUM_ROWS
// -----------------------------------------------------------------------------
module tb_memc_deskew;

   localparam int BITS_C   = 24;
   localparam int DIM      = 8;
   localparam int NUM_ROWS = 8;
   localparam int RIW      = 3;
   localparam int MAXC     = 8192;

   typedef logic [DIM-1:0][BITS_C-1:0] row_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic           rst;
   logic           in_valid;
   row_t           cin_s;
   logic           out_valid;
   row_t           cout_s;
   logic [RIW-1:0] row_idx;
   logic           last_row;

   memc_deskew #(
      .BITS_C  (BITS_C),
      .DIM     (DIM),
      .NUM_ROWS(NUM_ROWS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .Cin      (cin_s),
      .out_valid(out_valid),
      .Cout     (cout_s),
      .row_idx  (row_idx),
      .last_row (last_row)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic rst_h [MAXC];
   logic iv_h  [MAXC];
   row_t cin_h [MAXC];

   logic m_valid      = 1'b0;
   logic m_prev_valid = 1'b0;
   int   m_idx        = 0;
   row_t m_cout       = '0;

   int ov_cnt = 0;
   int lr_cnt = 0;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
      end
   endtask

   function automatic row_t rand_row();
      row_t d;
      for (int i = 0; i < DIM; i++) begin
         d[i] = BITS_C'($urandom);
      end
      return d;
   endfunction

   // Apply the inputs for one cycle, clock the DUT, advance the model, and
   // compare at the falling edge.
   task automatic step(input logic r, input logic iv, input row_t d);
      logic ok;
      if (cyc >= MAXC - 1) begin
         $display("FAIL cycle_budget cyc=%0d got=%0d exp=%0d", cyc, cyc, MAXC - 1);
         $fatal(1, "cycle budget exhausted");
      end
      rst        = r;
      in_valid   = iv;
      cin_s      = d;
      rst_h[cyc] = r;
      iv_h[cyc]  = iv;
      cin_h[cyc] = d;
      @(posedge clk);
      cyc++;
      @(negedge clk);

      m_valid = 1'b0;
      if (cyc >= DIM && iv_h[cyc-DIM]) begin
         ok = 1'b1;
         for (int k = cyc - DIM; k < cyc; k++) begin
            if (rst_h[k]) ok = 1'b0;
         end
         m_valid = ok;
      end
      if (rst_h[cyc-1]) m_idx = 0;
      else if (m_prev_valid) m_idx = (m_idx + 1) % NUM_ROWS;
      if (rst_h[cyc-1]) m_cout = '0;
      else if (m_valid) begin
         for (int i = 0; i < DIM; i++) begin
            m_cout[i] = cin_h[cyc-DIM+i][i];
         end
      end
      m_prev_valid = m_valid;

      check_val("out_valid", 256'(out_valid), 256'(m_valid));
      check_val("row_idx", 256'(row_idx), 256'(m_idx));
      check_val("last_row", 256'(last_row), 256'(m_valid && (m_idx == NUM_ROWS - 1)));
      check_val("cout", 256'(cout_s), 256'(m_cout));
      ov_cnt += int'(out_valid);
      lr_cnt += int'(last_row);
   endtask

   initial begin
      row_t d;
      int   v;

      // Reset with random data on Cin.
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, rand_row());
      for (int k = 0; k < 2; k++) step(1'b0, 1'b0, '0);

      // Single row: lane i = 10*i+1 inside its window, zero outside it.
      ov_cnt = 0;
      for (int k = 0; k < DIM + 3; k++) begin
         d = '0;
         if (k < DIM) d[k] = BITS_C'(10 * k + 1);
         step(1'b0, k == 0, d);
      end
      check_val("single_rows", 256'(ov_cnt), 256'(1));

      // Full matrix sent back-to-back; odd lanes carry negated values.
      step(1'b1, 1'b0, rand_row());
      ov_cnt = 0;
      lr_cnt = 0;
      for (int k = 0; k < DIM + 10; k++) begin
         d = '0;
         for (int i = 0; i < DIM; i++) begin
            if (k - i >= 0 && k - i < NUM_ROWS) begin
               v    = (k - i) * 16 + i;
               d[i] = (i % 2 == 1) ? BITS_C'(-v) : BITS_C'(v);
            end
         end
         step(1'b0, k < NUM_ROWS, d);
      end
      check_val("matrix_rows", 256'(ov_cnt), 256'(NUM_ROWS));
      check_val("matrix_last", 256'(lr_cnt), 256'(1));

      // Rows separated by gaps, with random data on Cin in every cycle.
      step(1'b1, 1'b0, rand_row());
      ov_cnt = 0;
      for (int k = 0; k < 15; k++) step(1'b0, (k == 0) || (k == 3), rand_row());
      check_val("gapped_rows", 256'(ov_cnt), 256'(2));

      // Reset while four rows are still in flight.
      step(1'b1, 1'b0, rand_row());
      ov_cnt = 0;
      for (int k = 0; k < 14; k++) step(k == 5, k < 4, rand_row());
      check_val("flushed_rows", 256'(ov_cnt), 256'(0));
      for (int k = 0; k < DIM + 2; k++) step(1'b0, k == 0, rand_row());
      check_val("post_flush_rows", 256'(ov_cnt), 256'(1));

      // Signed extreme values on alternating lanes.
      for (int k = 0; k < DIM + 6; k++) begin
         for (int i = 0; i < DIM; i++) begin
            d[i] = (i % 2 == 0) ? 24'h800000 : 24'h7FFFFF;
         end
         step(1'b0, k < 4, d);
      end

      // Random traffic with occasional resets.
      for (int n = 0; n < 1500; n++) begin
         step($urandom_range(0, 49) == 0, $urandom_range(0, 9) < 4, rand_row());
      end
      for (int k = 0; k < DIM + 2; k++) step(1'b0, 1'b0, rand_row());

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
